// File: rtl/idli_pkg.sv
// Shared types and constants for the idli core: SQI bus nibble type, fetch
// state encoding, SRAM command/phase lengths and the fetch address-nibble helper.
package idli_pkg;

  typedef logic [3:0] sqi_data_t;

  typedef enum logic [2:0] {
    FCH_IDLE,
    FCH_CMD,
    FCH_ADDR,
    FCH_DUMMY,
    FCH_DATA
  } fch_state_t;

  localparam logic [7:0] SQI_CMD_READ      = 8'h03;
  localparam int         SQI_CMD_NIBBLES   = 2;
  localparam int         SQI_ADDR_NIBBLES  = 6;
  localparam int         SQI_DUMMY_NIBBLES = 2;

  // Byte address {7'b0, pc, 1'b0}; idx 0 selects bits [23:20].
  function automatic sqi_data_t sqi_addr_nibble(input logic [15:0] pc,
                                                input logic [2:0]  idx);
    logic [23:0] addr;
    addr = {7'b0, pc, 1'b0};
    case (idx)
      3'd0:    return addr[23:20];
      3'd1:    return addr[19:16];
      3'd2:    return addr[15:12];
      3'd3:    return addr[11:8];
      3'd4:    return addr[7:4];
      default: return addr[3:0];
    endcase
  endfunction

endpackage

// File: rtl/idli_fetch_m.sv
// Instruction fetch front-end: issues an SQI sequential read at the PC and streams
// returned nibbles to the decoder. Define IDLI_FCH_DBG_PC_EN to expose o_fch_dbg_pc.
module idli_fetch_m
  import idli_pkg::*;
(
  input  logic        i_fch_gck,
  input  logic        i_fch_rst_n,
  input  logic        i_fch_run,
  input  logic        i_fch_redirect,
  input  logic [15:0] i_fch_redirect_pc,
  output logic        o_fch_sqi_cs_n,
  output logic        o_fch_sqi_oe,
  output sqi_data_t   o_fch_sqi_data,
  input  sqi_data_t   i_fch_sqi_data,
  output sqi_data_t   o_fch_enc,
  output logic        o_fch_enc_vld
`ifdef IDLI_FCH_DBG_PC_EN
  ,
  output logic [15:0] o_fch_dbg_pc
`endif
);

  localparam logic [2:0] CMD_LAST   = 3'(SQI_CMD_NIBBLES - 1);
  localparam logic [2:0] ADDR_LAST  = 3'(SQI_ADDR_NIBBLES - 1);
  localparam logic [2:0] DUMMY_LAST = 3'(SQI_DUMMY_NIBBLES - 1);
  localparam logic [2:0] WORD_LAST  = 3'd3;

  fch_state_t  state;
  logic [2:0]  cnt;
  logic [15:0] pc;

  // Outputs are loaded on the same edge that enters the state/count they belong to.
  always_ff @(posedge i_fch_gck or negedge i_fch_rst_n) begin
    if (!i_fch_rst_n) begin
      state          <= FCH_IDLE;
      cnt            <= '0;
      pc             <= '0;
      o_fch_sqi_cs_n <= 1'b1;
      o_fch_sqi_oe   <= 1'b0;
      o_fch_sqi_data <= '0;
      o_fch_enc      <= '0;
      o_fch_enc_vld  <= 1'b0;
    end else if (i_fch_redirect) begin
      state          <= FCH_IDLE;
      cnt            <= '0;
      pc             <= i_fch_redirect_pc;
      o_fch_sqi_cs_n <= 1'b1;
      o_fch_sqi_oe   <= 1'b0;
      o_fch_sqi_data <= '0;
      o_fch_enc_vld  <= 1'b0;
    end else begin
      o_fch_enc_vld <= (state == FCH_DATA);
      if (state == FCH_DATA) begin
        o_fch_enc <= i_fch_sqi_data;
      end
      case (state)
        FCH_IDLE: begin
          if (i_fch_run) begin
            state          <= FCH_CMD;
            cnt            <= '0;
            o_fch_sqi_cs_n <= 1'b0;
            o_fch_sqi_oe   <= 1'b1;
            o_fch_sqi_data <= SQI_CMD_READ[7:4];
          end
        end
        FCH_CMD: begin
          if (cnt == CMD_LAST) begin
            state          <= FCH_ADDR;
            cnt            <= '0;
            o_fch_sqi_data <= sqi_addr_nibble(pc, 3'd0);
          end else begin
            cnt            <= cnt + 3'd1;
            o_fch_sqi_data <= SQI_CMD_READ[3:0];
          end
        end
        FCH_ADDR: begin
          if (cnt == ADDR_LAST) begin
            state          <= FCH_DUMMY;
            cnt            <= '0;
            o_fch_sqi_oe   <= 1'b0;
            o_fch_sqi_data <= '0;
          end else begin
            cnt            <= cnt + 3'd1;
            o_fch_sqi_data <= sqi_addr_nibble(pc, cnt + 3'd1);
          end
        end
        FCH_DUMMY: begin
          if (cnt == DUMMY_LAST) begin
            state <= FCH_DATA;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        FCH_DATA: begin
          // The SRAM's own sequential counter tracks this PC, wrapping identically.
          if (cnt == WORD_LAST) begin
            cnt <= '0;
            pc  <= pc + 16'd1;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        default: begin
          state          <= FCH_IDLE;
          cnt            <= '0;
          o_fch_sqi_cs_n <= 1'b1;
          o_fch_sqi_oe   <= 1'b0;
          o_fch_sqi_data <= '0;
        end
      endcase
    end
  end

`ifdef IDLI_FCH_DBG_PC_EN
  always_ff @(posedge i_fch_gck or negedge i_fch_rst_n) begin
    if (!i_fch_rst_n) begin
      o_fch_dbg_pc <= '0;
    end else if (!i_fch_redirect && state == FCH_DATA && cnt == 3'd0) begin
      o_fch_dbg_pc <= pc;
    end
  end
`endif

endmodule

// File: tb/tb_idli_fetch_m.sv
// Directed/randomised bench for idli_fetch_m: acts as the SQI SRAM and checks the
// bus protocol and decoder stream against an address-based memory model.
`timescale 1ns/1ps
module tb_idli_fetch_m;
  import idli_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        cs_n;
  logic        oe;
  sqi_data_t   sqi_out;
  sqi_data_t   sqi_in = '0;
  sqi_data_t   enc;
  logic        enc_vld;
`ifdef IDLI_FCH_DBG_PC_EN
  logic [15:0] dbg_pc;
`endif

  int          passed = 0;
  int          total  = 0;
  int          fails  = 0;
  logic [15:0] model_pc = '0;
  logic [15:0] mem_seed = '0;

  always #5 clk = ~clk;

  idli_fetch_m dut (
    .i_fch_gck         (clk),
    .i_fch_rst_n       (rst_n),
    .i_fch_run         (run),
    .i_fch_redirect    (redirect),
    .i_fch_redirect_pc (redirect_pc),
    .o_fch_sqi_cs_n    (cs_n),
    .o_fch_sqi_oe      (oe),
    .o_fch_sqi_data    (sqi_out),
    .i_fch_sqi_data    (sqi_in),
    .o_fch_enc         (enc),
    .o_fch_enc_vld     (enc_vld)
`ifdef IDLI_FCH_DBG_PC_EN
    ,
    .o_fch_dbg_pc      (dbg_pc)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // SRAM contents: one 16-bit instruction word per word address.
  function automatic logic [15:0] mem_word(input logic [15:0] w);
    logic [15:0] v;
    v = (w * 16'h9E37) ^ mem_seed;
    return v;
  endfunction

  // Nibble k of the big-endian stream that starts at word address pc.
  function automatic logic [3:0] exp_nib(input logic [15:0] pc, input int k);
    logic [15:0] w;
    w = mem_word(pc + 16'(k / 4));
    return w[15 - 4 * (k % 4) -: 4];
  endfunction

  // Call from a cycle where the next edge starts CMD; ends in DATA after n nibbles.
  task automatic stream(input int n);
    logic [31:0] hdr;
    logic [15:0] pc0;
    pc0 = model_pc;
    hdr = 32'h0300_0000 | (32'(pc0) << 1);
    for (int c = 0; c < 10; c++) begin
      step();
      check("hdr_cs_n", 32'(cs_n), 32'd0);
      check("hdr_oe", 32'(oe), (c < 8) ? 32'd1 : 32'd0);
      check("hdr_data", 32'(sqi_out), (c < 8) ? ((hdr >> (28 - 4 * c)) & 32'hF) : 32'd0);
      check("hdr_vld", 32'(enc_vld), 32'd0);
      if (c == 0) run = 1'($urandom_range(0, 1));
    end
    for (int k = 0; k <= n; k++) begin
      step();
      check("data_cs_n", 32'(cs_n), 32'd0);
      check("data_oe", 32'(oe), 32'd0);
      if (k > 0) begin
        check("enc", 32'(enc), 32'(exp_nib(pc0, k - 1)));
        check("enc_vld", 32'(enc_vld), 32'd1);
`ifdef IDLI_FCH_DBG_PC_EN
        check("dbg_pc", 32'(dbg_pc), 32'(pc0 + 16'((k - 1) / 4)));
`endif
      end
      sqi_in = (k < n) ? exp_nib(pc0, k) : 4'($urandom);
    end
    model_pc = pc0 + 16'(n / 4);
  endtask

  task automatic do_redirect(input logic [15:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    run         = 1'b1;
    step();
    redirect    = 1'b0;
    model_pc    = pc;
    check("rd_cs_n", 32'(cs_n), 32'd1);
    check("rd_oe", 32'(oe), 32'd0);
    check("rd_vld", 32'(enc_vld), 32'd0);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_oe", 32'(oe), 32'd0);
    check("rst_data", 32'(sqi_out), 32'd0);
    check("rst_enc", 32'(enc), 32'd0);
    check("rst_vld", 32'(enc_vld), 32'd0);
`ifdef IDLI_FCH_DBG_PC_EN
    check("rst_dbg", 32'(dbg_pc), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Run gating: nothing happens while run is low
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_cs_n", 32'(cs_n), 32'd1);
    end

    // First fetch from PC 0, word 0 holds 0xA5C3
    mem_seed = 16'hA5C3;
    model_pc = 16'h0000;
    run = 1'b1;
    stream(8);

    // Redirect while streaming
    mem_seed = 16'($urandom);
    do_redirect(16'h1234);
    stream(8);

    // Redirect in ADDR, then again in the gap cycle
    do_redirect(16'($urandom));
    for (int c = 0; c < 5; c++) begin
      step();
      check("addr_cs_n", 32'(cs_n), 32'd0);
      check("addr_vld", 32'(enc_vld), 32'd0);
    end
    do_redirect(16'($urandom));
    do_redirect(16'($urandom));
    stream(5);

    // PC wrap across 0xFFFF
    do_redirect(16'hFFFF);
    stream(8);

    // Random redirect targets and stream lengths (mid-word redirects included)
    for (int i = 0; i < 10; i++) begin
      mem_seed = 16'($urandom);
      do_redirect(16'($urandom));
      stream(int'($urandom_range(1, 14)));
    end

    // Asynchronous reset mid-DATA
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_cs_n", 32'(cs_n), 32'd1);
    check("arst_oe", 32'(oe), 32'd0);
    check("arst_vld", 32'(enc_vld), 32'd0);
    check("arst_enc", 32'(enc), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run = 1'b1;
    model_pc = 16'h0000;
    stream(6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
